fsmd_gray_decoder: RTL and testbench

FSMD_GRAY_DECODER -- requirements
Module: fsmd_gray_decoder

---
 rtl/fsmd_gray_decoder.sv | 148 ++++++++++++++
 tb/tb_fsmd_gray_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fsmd_gray_decoder.sv
// Serial Gray-to-binary decoder: one result bit per clock, MSB first, with a
// check that each decoded code is exactly one bit away from the previous one.
module fsmd_gray_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             done,
    output logic             busy,
    output logic             adj_err,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request that is only taken in IDLE (when busy is low);
    // gray_in is captured on that same edge. done is a single-cycle pulse, and
    // bin_out/adj_err are valid with it and hold until the next done.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] g_reg_q, g_reg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             prev_bit_q, prev_bit_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             adj_err_q, adj_err_d;
    logic [WIDTH-1:0] g_prev_q, g_prev_d;
    logic             have_prev_q, have_prev_d;

    logic             accept;
    logic             last_bit;
    logic [CW-1:0]    bit_idx;
    logic             new_bit;
    logic [WIDTH-1:0] diff;
    logic             one_bit_step;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CONV;
            S_CONV:  if (cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: purely from the state register, so start never reaches busy.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = state_q;
        case (state_q)
            S_CONV:  busy = 1'b1;
            S_DONE:  begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign bin_out = bin_q;
    assign adj_err = adj_err_q;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_bit = (state_q == S_CONV) && (cnt_q == LAST_CNT);

    // Bit k of the scan resolves result bit WIDTH-1-k; the running XOR of all
    // higher Gray bits lives in prev_bit_q so the MSB simply sees a zero seed.
    assign bit_idx = LAST_CNT - cnt_q;
    assign new_bit = prev_bit_q ^ g_reg_q[bit_idx];

    assign diff         = g_reg_q ^ g_prev_q;
    assign one_bit_step = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

    always_comb begin
        cnt_d       = cnt_q;
        g_reg_d     = g_reg_q;
        acc_d       = acc_q;
        prev_bit_d  = prev_bit_q;
        bin_d       = bin_q;
        adj_err_d   = adj_err_q;
        g_prev_d    = g_prev_q;
        have_prev_d = have_prev_q;
        if (accept) begin
            g_reg_d    = gray_in;
            cnt_d      = '0;
            acc_d      = '0;
            prev_bit_d = 1'b0;
        end else if (state_q == S_CONV) begin
            acc_d[bit_idx] = new_bit;
            prev_bit_d     = new_bit;
            cnt_d          = cnt_q + CW'(1);
            if (last_bit) begin
                bin_d       = acc_d;
                adj_err_d   = have_prev_q && !one_bit_step;
                g_prev_d    = g_reg_q;
                have_prev_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            g_reg_q     <= '0;
            acc_q       <= '0;
            prev_bit_q  <= 1'b0;
            bin_q       <= '0;
            adj_err_q   <= 1'b0;
            g_prev_q    <= '0;
            have_prev_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            g_reg_q     <= g_reg_d;
            acc_q       <= acc_d;
            prev_bit_q  <= prev_bit_d;
            bin_q       <= bin_d;
            adj_err_q   <= adj_err_d;
            g_prev_q    <= g_prev_d;
            have_prev_q <= have_prev_d;
        end
    end

endmodule

// File: tb/tb_fsmd_gray_decoder.sv
// Bench for fsmd_gray_decoder: directed cases plus randomized conversions
// compared against an arithmetic Gray-decode and adjacency model.
module tb_fsmd_gray_decoder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] bin_out;
    logic         done;
    logic         busy;
    logic         adj_err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_prev = '0;
    logic         m_have = 1'b0;

    fsmd_gray_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .done      (done),
        .busy      (busy),
        .adj_err   (adj_err),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model: binary = XOR of all right shifts of the Gray code.
    function automatic logic [W-1:0] model_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic model_adj(input logic [W-1:0] g);
        return m_have && ($countones(g ^ m_prev) != 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion from IDLE; noise drives random start/gray_in while busy.
    task automatic convert(input logic [W-1:0] g, input bit noise, input string tag);
        logic [W-1:0] exp_b;
        logic         exp_a;
        start   = 1'b1;
        gray_in = g;
        @(posedge clk);
        #1;
        exp_q.push_back(model_bin(g));
        exp_a = model_adj(g);
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) gray_in = W'($urandom);
        for (int c = 0; c <= W; c++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done"}, 32'(done), (c == W) ? 32'd1 : 32'd0);
            if (c == W) begin
                exp_b = exp_q.pop_front();
                check({tag, "_bin"}, 32'(bin_out), 32'(exp_b));
                check({tag, "_adj"}, 32'(adj_err), 32'(exp_a));
                m_prev = g;
                m_have = 1'b1;
            end
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                gray_in = W'($urandom);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_hold_bin"}, 32'(bin_out), 32'(model_bin(g)));
    endtask

    initial begin
        int last_done;
        int n_done;
        logic [W-1:0] g;

        // Reset held low across edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bin", 32'(bin_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_adj", 32'(adj_err), 32'd0);

        // Release, then the very next edge must accept a start
        @(posedge clk);
        #1;
        rst = 1'b1;
        convert(4'b1111, 1'b0, "g1111");
        check("g1111_val", 32'(bin_out), 32'b1010);
        convert(4'b1110, 1'b0, "g1110");
        check("g1110_val", 32'(bin_out), 32'b1011);
        convert(4'b1011, 1'b0, "g1011");
        check("g1011_val", 32'(bin_out), 32'b1101);
        check("g1011_err", 32'(adj_err), 32'd1);
        convert(4'b1011, 1'b0, "g1011_rep");
        check("g1011_rep_err", 32'(adj_err), 32'd1);

        // Start re-pulsed in CONV cycle 2 with a new operand: ignored
        start   = 1'b1;
        gray_in = 4'b0110;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ign_c1_done", 32'(done), 32'd0);
        start   = 1'b1;
        gray_in = 4'b1001;
        @(negedge clk);
        check("ign_c2_done", 32'(done), 32'd0);
        start   = 1'b0;
        n_done  = 0;
        for (int c = 2; c <= W + 4; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check("ign_bin", 32'(bin_out), 32'(model_bin(4'b0110)));
                check("ign_adj", 32'(adj_err), 32'(model_adj(4'b0110)));
                check("ign_at", c, W);
            end
        end
        check("ign_one_done", n_done, 1);
        m_prev = 4'b0110;
        m_have = 1'b1;

        // Reset during CONV cycle 2: immediate, no done, history cleared
        start   = 1'b1;
        gray_in = 4'b0110;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("abort_c1_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_c2_done", 32'(done), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("async_bin", 32'(bin_out), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_adj", 32'(adj_err), 32'd0);
        m_have = 1'b0;
        m_prev = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        convert(4'b0001, 1'b0, "g0001");
        check("g0001_val", 32'(bin_out), 32'b0001);
        check("g0001_err", 32'(adj_err), 32'd0);

        // Start held high: a new conversion every W+2 cycles
        start     = 1'b1;
        gray_in   = 4'b0101;
        n_done    = 0;
        last_done = -1;
        for (int c = 0; c < 40 && n_done < 3; c++) begin
            @(negedge clk);
            if (done) begin
                check("held_bin", 32'(bin_out), 32'(model_bin(4'b0101)));
                check("held_adj", 32'(adj_err), 32'(model_adj(4'b0101)));
                m_prev = 4'b0101;
                m_have = 1'b1;
                if (last_done >= 0) check("held_period", c - last_done, W + 2);
                else check("held_first", c, W);
                last_done = c;
                n_done++;
            end
        end
        start = 1'b0;
        check("held_count", n_done, 3);
        @(negedge clk);
        @(negedge clk);
        check("held_idle", 32'(busy), 32'd0);

        // Randomized conversions, biased toward one-bit steps
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) == 0) g = W'($urandom);
            else g = m_prev ^ (W'(1) << $urandom_range(0, W - 1));
            convert(g, 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
